// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized input, N-times oversampled bits with
// 2-of-3 majority voting, optional even/odd parity and a half-bit-early stop.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PAR_EN     = 1,
  parameter int PAR_TYPE   = 0,
  parameter int N          = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  output logic [DATA_WIDTH-1:0] P_DATA_OUT,
  output logic                  DATA_VALID,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  busy_flag
);

  localparam int CW = $clog2(N);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] SAMP_0   = CW'(N / 2 - 1);
  localparam logic [CW-1:0] SAMP_1   = CW'(N / 2);
  localparam logic [CW-1:0] SAMP_2   = CW'(N / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic                  sync1_r;
  logic                  rx_s;
  logic [2:0]            state_r;
  logic [2:0]            state_nxt_s;
  logic [CW-1:0]         edge_cnt_r;
  logic [BW-1:0]         bit_idx_r;
  logic                  samp0_r;
  logic                  samp1_r;
  logic                  bit_r;
  logic                  par_err_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] shift_nxt_s;
  logic                  maj_s;
  logic                  bit_val_s;
  logic                  cnt_end_s;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_r <= RX_IN;
      rx_s    <= sync1_r;
    end
  end

  // Bit voting, shift-in value and next-state decode
  always_comb begin
    maj_s       = majority3(samp0_r, samp1_r, rx_s);
    // When the third sample and the bit end coincide (N=4) use the live vote
    bit_val_s   = (edge_cnt_r == SAMP_2) ? maj_s : bit_r;
    cnt_end_s   = (edge_cnt_r == CNT_LAST);
    shift_nxt_s = shift_r >> 1;
    shift_nxt_s[DATA_WIDTH-1] = bit_val_s;
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (rx_s == 1'b0) state_nxt_s = START;
        else              state_nxt_s = IDLE;
      end
      START: begin
        if (cnt_end_s) state_nxt_s = bit_val_s ? IDLE : DATA;
        else           state_nxt_s = START;
      end
      DATA: begin
        if (cnt_end_s && (bit_idx_r == BIT_LAST)) state_nxt_s = (PAR_EN != 0) ? PARITY : STOP;
        else                                      state_nxt_s = DATA;
      end
      PARITY: begin
        if (cnt_end_s) state_nxt_s = STOP;
        else           state_nxt_s = PARITY;
      end
      STOP: begin
        if (edge_cnt_r == SAMP_2) state_nxt_s = IDLE;
        else                      state_nxt_s = STOP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state, in-bit edge counter and mid-bit samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      busy_flag  <= 1'b0;
      edge_cnt_r <= '0;
      samp0_r    <= 1'b1;
      samp1_r    <= 1'b1;
      bit_r      <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      busy_flag <= (state_nxt_s != IDLE);
      // The detecting edge counts as edge 0, so the next edge is edge 1
      if (state_r == IDLE)           edge_cnt_r <= rx_s ? CW'(0) : CW'(1);
      else if (state_nxt_s == IDLE)  edge_cnt_r <= CW'(0);
      else if (cnt_end_s)            edge_cnt_r <= CW'(0);
      else                           edge_cnt_r <= edge_cnt_r + CW'(1);
      if (state_r != IDLE && edge_cnt_r == SAMP_0) samp0_r <= rx_s;
      if (state_r != IDLE && edge_cnt_r == SAMP_1) samp1_r <= rx_s;
      if (state_r != IDLE && edge_cnt_r == SAMP_2) bit_r   <= maj_s;
    end
  end

  // Data shift register, bit index and parity check
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r   <= '0;
      bit_idx_r <= '0;
      par_err_r <= 1'b0;
    end else begin
      case (state_r)
        START: begin
          bit_idx_r <= '0;
          par_err_r <= 1'b0;
        end
        DATA: begin
          if (cnt_end_s) begin
            shift_r   <= shift_nxt_s;
            bit_idx_r <= (bit_idx_r == BIT_LAST) ? BW'(0) : bit_idx_r + BW'(1);
          end
        end
        PARITY: begin
          if (cnt_end_s) par_err_r <= (bit_val_s != calc_parity(shift_r, PAR_TYPE != 0));
        end
        default: begin
          bit_idx_r <= bit_idx_r;
        end
      endcase
    end
  end

  // Registered result pulses, decided half a bit into the stop bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      P_DATA_OUT   <= '0;
      DATA_VALID   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      DATA_VALID   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      if (state_r == STOP && edge_cnt_r == SAMP_2) begin
        stop_error   <= ~maj_s;
        parity_error <= par_err_r;
        DATA_VALID   <= maj_s & ~par_err_r;
        if (maj_s && !par_err_r) P_DATA_OUT <= shift_r;
      end
    end
  end

endmodule
